// File: rtl/irq_controller.sv
// Interrupt aggregator: rising-edge capture of up to eight request lines into a
// pending register, fixed-priority one-at-a-time dispatch to the CPU, and MMIO regs.
module irq_controller #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               bus_we,
  input  logic [1:0]         bus_addr,
  input  logic [7:0]         bus_wdata,
  output logic [7:0]         bus_rdata,
  output logic               cpu_int,
  input  logic               cpu_ack,
  output logic [2:0]         int_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               cpu_int_q, cpu_int_d;
  logic [2:0]         int_id_q, int_id_d;

  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] sw_clr;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] pick_onehot;
  logic [NUM_IRQ-1:0] dispatch_clr;
  logic [2:0]         pick;
  logic [7:0]         mask_ext;
  logic [7:0]         pending_ext;

  always_comb begin
    edge_det   = irq_in & ~irq_prev_q;
    irq_prev_d = irq_in;

    sw_set = '0;
    sw_clr = '0;
    mask_d = mask_q;
    if (bus_we) begin
      case (bus_addr)
        2'd0:    mask_d = bus_wdata[NUM_IRQ-1:0];
        2'd1:    sw_clr = bus_wdata[NUM_IRQ-1:0];
        2'd3:    sw_set = bus_wdata[NUM_IRQ-1:0];
        default: ;
      endcase
    end

    // Scan from the top down so the lowest enabled index ends up winning.
    req         = pending_q & mask_q;
    pick        = '0;
    pick_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick           = 3'(i);
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
      end
    end

    state_d      = state_q;
    cpu_int_d    = cpu_int_q;
    int_id_d     = int_id_q;
    dispatch_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          int_id_d     = pick;
          cpu_int_d    = 1'b1;
          dispatch_clr = pick_onehot;
          state_d      = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (cpu_ack) begin
          cpu_int_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        cpu_int_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        cpu_int_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Set sources are OR-ed in last so they override any same-cycle clear.
    pending_d = (pending_q & ~(sw_clr | dispatch_clr)) | edge_det | sw_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      cpu_int_q  <= 1'b0;
      int_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      cpu_int_q  <= cpu_int_d;
      int_id_q   <= int_id_d;
    end
  end

  always_comb begin
    mask_ext                 = '0;
    pending_ext              = '0;
    mask_ext[NUM_IRQ-1:0]    = mask_q;
    pending_ext[NUM_IRQ-1:0] = pending_q;
    case (bus_addr)
      2'd0:    bus_rdata = mask_ext;
      2'd1:    bus_rdata = pending_ext;
      2'd2:    bus_rdata = {4'b0, (state_q != S_IDLE), int_id_q};
      default: bus_rdata = 8'h00;
    endcase
  end

  assign cpu_int = cpu_int_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the interrupt controller.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       bus_we = 1'b0;
  logic [1:0] bus_addr = '0;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic       cpu_int;
  logic       cpu_ack = 1'b0;
  logic [2:0] int_id;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_IRQ(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_in    (irq_in),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .cpu_int   (cpu_int),
    .cpu_ack   (cpu_ack),
    .int_id    (int_id)
  );

  always #5 clk = ~clk;

  // Reference model: interrupt outstanding flag, one-cycle cool-down flag, pending set.
  logic [7:0] m_prev = '0;
  logic [7:0] m_pend = '0;
  logic [7:0] m_mask = '0;
  bit         m_int = 1'b0;
  bit         m_gap = 1'b0;
  int         m_id = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev = '0; m_pend = '0; m_mask = '0;
      m_int = 1'b0; m_gap = 1'b0; m_id = 0;
    end else begin
      model_step();
    end
  end

  task automatic model_step();
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] ready;
    int         k;
    set_bits = irq_in & ~m_prev;
    clr_bits = '0;
    m_prev   = irq_in;
    if (bus_we && bus_addr == 2'd3) set_bits = set_bits | bus_wdata;
    if (bus_we && bus_addr == 2'd1) clr_bits = bus_wdata;
    ready = m_pend & m_mask;
    if (!m_int && !m_gap) begin
      if (ready != 0) begin
        k = 0;
        while (ready[k] == 1'b0) k++;
        m_id     = k;
        m_int    = 1'b1;
        clr_bits = clr_bits | 8'(1 << k);
      end
    end else if (m_int) begin
      if (cpu_ack) begin
        m_int = 1'b0;
        m_gap = 1'b1;
      end
    end else begin
      m_gap = 1'b0;
    end
    m_pend = (m_pend & ~clr_bits) | set_bits;
    if (bus_we && bus_addr == 2'd0) m_mask = bus_wdata;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return {4'b0, (m_int || m_gap), 3'(m_id)};
      default: return 8'h00;
    endcase
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic ack_and_settle();
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_int: got %b expected 0", cpu_int); end
    checks++;
    if (int_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_int_id: got %0d expected 0", int_id); end
    for (int a = 0; a < 4; a++) begin
      bus_addr = 2'(a);
      #1;
      checks++;
      if (bus_rdata !== 8'h00)
        begin errors++; $display("[TB] FAIL reset_read_addr%0d: got %02h expected 00", a, bus_rdata); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    irq_in = 8'h01;
    @(negedge clk);
    bus_addr = 2'd1;
    #1;
    checks++;
    if (bus_rdata !== 8'h01) begin errors++; $display("[TB] FAIL reset_masked_pending: got %02h expected 01", bus_rdata); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL reset_masked_no_int: got %b expected 0", cpu_int); end
    end
    irq_in = 8'h00;
    bus_write(2'd1, 8'hFF);
  endtask

  task automatic test_timer();
    bus_write(2'd0, 8'hFF);
    irq_in = 8'h01;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      cpu_ack = 1'b0;
      if (c == 1) begin
        checks++;
        if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL timer_early: got %b expected 0", cpu_int); end
      end else if (c == 2 || c == 3) begin
        checks++;
        if (cpu_int !== 1'b1 || int_id !== 3'd0)
          begin errors++; $display("[TB] FAIL timer_dispatch: got int=%b id=%0d expected int=1 id=0", cpu_int, int_id); end
      end else begin
        checks++;
        if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL timer_single_edge c%0d: got %b expected 0", c, cpu_int); end
      end
      if (c == 3) cpu_ack = 1'b1;
    end
    irq_in = 8'h00;
    @(negedge clk);
    bus_addr = 2'd1;
    #1;
    checks++;
    if (bus_rdata !== 8'h00) begin errors++; $display("[TB] FAIL timer_pending_clear: got %02h expected 00", bus_rdata); end
  endtask

  task automatic test_priority();
    irq_in = 8'h24;
    repeat (2) @(negedge clk);
    irq_in = 8'h00;
    checks++;
    if (cpu_int !== 1'b1 || int_id !== 3'd2)
      begin errors++; $display("[TB] FAIL prio_first: got int=%b id=%0d expected int=1 id=2", cpu_int, int_id); end
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL prio_ack_drop: got %b expected 0", cpu_int); end
    @(negedge clk);
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL prio_gap: got %b expected 0", cpu_int); end
    @(negedge clk);
    checks++;
    if (cpu_int !== 1'b1 || int_id !== 3'd5)
      begin errors++; $display("[TB] FAIL prio_second: got int=%b id=%0d expected int=1 id=5", cpu_int, int_id); end
    bus_addr = 2'd2;
    #1;
    checks++;
    if (bus_rdata !== 8'h0D) begin errors++; $display("[TB] FAIL prio_status_read: got %02h expected 0D", bus_rdata); end
    ack_and_settle();
  endtask

  task automatic test_masking();
    bus_write(2'd0, 8'h00);
    irq_in = 8'h08;
    @(negedge clk);
    irq_in = 8'h00;
    repeat (2) @(negedge clk);
    bus_addr = 2'd1;
    #1;
    checks++;
    if (bus_rdata !== 8'h08) begin errors++; $display("[TB] FAIL mask_pending: got %02h expected 08", bus_rdata); end
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL mask_blocks: got %b expected 0", cpu_int); end
    bus_write(2'd0, 8'h08);
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL mask_write_early: got %b expected 0", cpu_int); end
    @(negedge clk);
    checks++;
    if (cpu_int !== 1'b1 || int_id !== 3'd3)
      begin errors++; $display("[TB] FAIL mask_unmask_dispatch: got int=%b id=%0d expected int=1 id=3", cpu_int, int_id); end
    ack_and_settle();
  endtask

  task automatic test_collision();
    bus_write(2'd0, 8'h00);
    irq_in = 8'h10;
    bus_write(2'd1, 8'h10);
    irq_in = 8'h00;
    bus_addr = 2'd1;
    #1;
    checks++;
    if (bus_rdata !== 8'h10) begin errors++; $display("[TB] FAIL collide_set_wins: got %02h expected 10", bus_rdata); end
    bus_write(2'd1, 8'h10);
    bus_write(2'd0, 8'h40);
    bus_write(2'd3, 8'h40);
    #1;
    checks++;
    if (bus_rdata !== 8'h00) begin errors++; $display("[TB] FAIL swset_read_zero: got %02h expected 00", bus_rdata); end
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL swset_early: got %b expected 0", cpu_int); end
    @(negedge clk);
    checks++;
    if (cpu_int !== 1'b1 || int_id !== 3'd6)
      begin errors++; $display("[TB] FAIL swset_dispatch: got int=%b id=%0d expected int=1 id=6", cpu_int, int_id); end
    ack_and_settle();
  endtask

  task automatic test_reset_mid();
    bus_write(2'd0, 8'hFF);
    irq_in = 8'h03;
    repeat (2) @(negedge clk);
    bus_addr = 2'd1;
    #1;
    checks++;
    if (cpu_int !== 1'b1 || int_id !== 3'd0 || bus_rdata !== 8'h02)
      begin errors++; $display("[TB] FAIL midrst_setup: got int=%b id=%0d pend=%02h expected 1/0/02", cpu_int, int_id, bus_rdata); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    irq_in = 8'h00;
    #1;
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drop: got %b expected 0", cpu_int); end
    checks++;
    if (bus_rdata !== 8'h00) begin errors++; $display("[TB] FAIL midrst_pending: got %02h expected 00", bus_rdata); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (cpu_int !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_dispatch: got %b expected 0", cpu_int); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_int !== m_int)
        begin errors++; $display("[TB] FAIL rand_cpu_int c%0d: got %b expected %b", c, cpu_int, m_int); end
      checks++;
      if (int_id !== 3'(m_id))
        begin errors++; $display("[TB] FAIL rand_int_id c%0d: got %0d expected %0d", c, int_id, m_id); end
      checks++;
      if (bus_rdata !== model_read(bus_addr))
        begin errors++; $display("[TB] FAIL rand_read c%0d addr%0d: got %02h expected %02h", c, bus_addr, bus_rdata, model_read(bus_addr)); end
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'(1 << $urandom_range(0, 7));
      bus_we    = ($urandom_range(0, 5) == 0);
      bus_addr  = 2'($urandom_range(0, 3));
      bus_wdata = 8'($urandom);
      if (bus_we && bus_addr == 2'd1) bus_wdata = bus_wdata & 8'($urandom);
      cpu_ack   = ($urandom_range(0, 2) == 0);
    end
    bus_we  = 1'b0;
    cpu_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_priority();
    test_masking();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt aggregation stage directly downstream of the one-shot timer and the other IO peripherals. It edge-detects up to eight interrupt request lines and latches them as pending. Sources such as the timer hold their request high for several cycles, so each rising edge counts exactly once. It dispatches one interrupt at a time to the CPU by fixed priority and exposes mask and pending registers on the memory-mapped IO bus.

## Interface
- `NUM_IRQ`, 8: number of interrupt sources (1..8); unused bits of 8-bit fields read 0.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `irq_in` input NUM_IRQ: request lines, active high, level held ≥1 cycle; bit 0 is the OS timer.
- `bus_we` input 1: register write strobe, one cycle per write.
- `bus_addr` input 2: register select.
- `bus_wdata` input 8: write data.
- `bus_rdata` output 8: read data, combinational from `bus_addr`.
- `cpu_int` output 1: interrupt request to CPU, held until acknowledged.
- `cpu_ack` input 1: CPU acknowledge, one-cycle pulse.
- `int_id` output 3: index of the interrupt being or last dispatched.

## Operation
- Edge detect:
  - `irq_prev` registers `irq_in` every cycle; reset value 0.
  - Edge on bit i = `irq_in[i] & ~irq_prev[i]`.
  - A line already high when reset releases counts as one edge.
- Pending register (`pending`, reset 0):
  - Bit i sets on edge i, regardless of mask.
  - Bit i sets on a software write of 1 to addr 3 bit i.
  - Bit i clears on a write of 1 to addr 1 bit i (W1C).
  - Bit i clears on dispatch of i.
  - Any set event in the same cycle as any clear event on the same bit: set wins.
- Mask register (`mask`, reset 0 = all disabled): only gates dispatch.
- Register map:
  - addr 0: mask, R/W.
  - addr 1: pending, R / W1C.
  - addr 2: read `{4'b0, busy, int_id}`, where busy = state ≠ S_IDLE; writes ignored.
  - addr 3: software set, W1S; reads 0.
- FSM (reset state S_IDLE):
  - S_IDLE:
    - If `pending & mask` ≠ 0, pick the lowest set index k.
    - Set `int_id`←k, clear pending[k], set `cpu_int`←1, go to S_ASSERT.
  - S_ASSERT:
    - Hold `cpu_int`=1 and `int_id` stable.
    - On `cpu_ack`: `cpu_int`←0, go to S_GAP.
    - Edges and writes during this state still update pending/mask.
  - S_GAP: one cycle with `cpu_int`=0, then go to S_IDLE.
  - `cpu_ack` outside S_ASSERT is ignored.
- Masking a source after dispatch does not retract `cpu_int`.
- Priority is static: index 0 is highest.

## Timing
- Reset values:
  - `cpu_int`=0, `int_id`=0.
  - `bus_rdata` reflects the register contents after reset: 0 for every address.
  - `pending`=0, `mask`=0, `irq_prev`=0.
- Reset is asynchronous and takes effect immediately. Asserting it mid-S_ASSERT drops `cpu_int` without waiting for ack and discards all pending interrupts.
- Latency:
  - `irq_in[i]` first sampled high at edge n → pending[i]=1 after edge n.
  - If unmasked and idle, `cpu_int`=1 after edge n+1 (2 cycles).
- Back-to-back dispatch:
  - `cpu_ack` sampled at edge m → `cpu_int`=0 after m, S_GAP through m+1.
  - Next `cpu_int`=1 after edge m+2 at the earliest.
- A mask write at edge n takes effect for the dispatch decision at edge n+1.
- A line held high for many cycles produces exactly one edge. It can generate another only after returning low for ≥1 cycle.
- A second edge on a bit already pending is absorbed; there is no counting.
- An edge on bit k in the cycle it is dispatched leaves pending[k]=1 (set wins), so it dispatches again afterwards.

## Test plan
- Reset:
  - Stimulus: assert `reset_n`=0 asynchronously mid-cycle.
  - Required: `cpu_int`=0, `int_id`=0, and reads of addr 0/1/2/3 return 0x00.
  - Required: with mask=0, raising `irq_in`=0x01 gives pending=0x01 and `cpu_int` stays 0.
- Timer path:
  - Stimulus: mask=0xFF; `irq_in[0]` high for 16 cycles.
  - Required: `cpu_int` rises 2 cycles after first high sample with `int_id`=0.
  - Required: after `cpu_ack`, no second interrupt occurs and pending=0x00.
- Priority:
  - Stimulus: mask=0xFF; bits 5 and 2 rise in the same cycle.
  - Required: first dispatch `int_id`=2, ack, one gap cycle, then `int_id`=5.
  - Required: addr 2 reads 0x0D while the second interrupt is asserted.
- Masking:
  - Stimulus: mask=0x00; edge on bit 3.
  - Required: pending=0x08 and no `cpu_int`.
  - Stimulus: write mask=0x08.
  - Required: `cpu_int` rises 2 cycles after the write with `int_id`=3.
- Set/clear collision:
  - Stimulus: W1C 0x10 to addr 1 in the same cycle as a bit-4 edge.
  - Required: pending bit 4 remains 1.
  - Stimulus: W1S 0x40 to addr 3 with mask=0x40.
  - Required: dispatches `int_id`=6.
- Reset mid-operation:
  - Stimulus: in S_ASSERT with another source pending, pulse `reset_n` low.
  - Required: `cpu_int` drops immediately, pending=0x00, and no dispatch after release.
